// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the L2 physical-memory port (one 256-bit line per
// request) to a 64-bit, 4-beat burst memory bus.
//   clk, rst              : clock, asynchronous active-high reset
//   line_i / line_o       : writeback line from L2 / assembled read line to L2
//   address_i             : line address from L2
//   read_i / write_i      : L2 line requests, held until resp_o
//   resp_o                : one-cycle completion pulse to L2
//   burst_i / burst_o     : read beat from memory / write beat to memory
//   address_o             : line-aligned burst address to memory
//   read_o / write_o      : burst requests to memory
//   resp_i                : memory beat-accept / beat-valid strobe
module cacheline_adaptor #(
  parameter int unsigned BURST_W  = 64,
  parameter int unsigned BEATS    = 4,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BURST_W*BEATS-1:0]   line_i,
  output logic [BURST_W*BEATS-1:0]   line_o,
  input  logic [31:0]                address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  output logic                       resp_o,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  output logic [31:0]                address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int unsigned LINE_W = BURST_W * BEATS;
  localparam int unsigned CNT_W  = $clog2(BEATS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  rbuf_q, rbuf_d;   // read beats shift in from the top
  logic [LINE_W-1:0]  wline_q, wline_d; // write line shifts out from the bottom
  logic [LINE_W-1:0]  line_d;
  logic [BURST_W-1:0] burst_d;
  logic [31:0]        addr_d;
  logic               read_d, write_d, resp_d;
  logic               last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    wline_d = wline_q;
    line_d  = line_o;
    addr_d  = address_o;

    case (state_q)
      IDLE: begin
        // Write wins if both are high; the address is captured only here.
        if (write_i) begin
          wline_d = line_i;
          addr_d  = {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = {address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          // After BEATS shifts, beat 0 lands in the lowest slice.
          rbuf_d = {burst_i, rbuf_q[LINE_W-1:BURST_W]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_beat) begin
            line_d  = rbuf_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          wline_d = wline_q >> BURST_W;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == DONE);
    burst_d = write_d ? wline_d[BURST_W-1:0] : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rbuf_q    <= '0;
      wline_q   <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rbuf_q    <= rbuf_d;
      wline_q   <= wline_d;
      line_o    <= line_d;
      burst_o   <= burst_d;
      address_o <= addr_d;
      read_o    <= read_d;
      write_o   <= write_d;
      resp_o    <= resp_d;
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed test of cacheline_adaptor with hand-computed
// expected lines, addresses and pulse timing.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int vectors    = 0;
  int miscompares = 0;
  int resp_cnt   = 0;

  localparam logic [255:0] L_RD1 =
    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [255:0] L_WR =
    256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
  localparam logic [255:0] L_RD2 =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0;
  localparam logic [255:0] L_RD3 =
    256'hCAFEF00DCAFEF00D_0000000000000001_8000000000000000_5A5A5A5A5A5A5A5A;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resp_o) resp_cnt <= resp_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read of one line; gN = idle cycles before beat N. Returns in the cycle
  // after resp_o with read_i already dropped.
  task automatic read_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] data, input int g0, input int g1,
                           input int g2, input int g3);
    int gaps[4];
    gaps = '{g0, g1, g2, g3};
    read_i    = 1'b1;
    address_i = addr;
    step();
    check("rd_addr", 256'(address_o), 256'(exp_addr));
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b0;
      for (int g = 0; g < gaps[k]; g++) begin
        check("rd_read_o_gap", 256'(read_o), 256'(1'b1));
        check("rd_resp_o_gap", 256'(resp_o), 256'(1'b0));
        step();
      end
      check("rd_read_o", 256'(read_o), 256'(1'b1));
      check("rd_resp_o_busy", 256'(resp_o), 256'(1'b0));
      resp_i  = 1'b1;
      burst_i = data[k*64 +: 64];
      step();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    check("rd_done_resp_o", 256'(resp_o), 256'(1'b1));
    check("rd_done_read_o", 256'(read_o), 256'(1'b0));
    check("rd_line_o", line_o, data);
    step();
    read_i = 1'b0;
    check("rd_resp_o_single", 256'(resp_o), 256'(1'b0));
    check("rd_line_o_hold", line_o, data);
  endtask

  // Writeback of one line with a single idle cycle before beat 1.
  task automatic write_line(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] data, input logic [255:0] prev_line);
    write_i   = 1'b1;
    line_i    = data;
    address_i = addr;
    step();
    check("wr_addr", 256'(address_o), 256'(exp_addr));
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        resp_i = 1'b0;
        check("wr_burst_o_gap", 256'(burst_o), 256'(data[k*64 +: 64]));
        step();
      end
      check("wr_write_o", 256'(write_o), 256'(1'b1));
      check("wr_read_o_low", 256'(read_o), 256'(1'b0));
      check("wr_burst_o", 256'(burst_o), 256'(data[k*64 +: 64]));
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    check("wr_done_write_o", 256'(write_o), 256'(1'b0));
    check("wr_done_resp_o", 256'(resp_o), 256'(1'b1));
    check("wr_line_o_kept", line_o, prev_line);
    step();
    write_i = 1'b0;
    line_i  = '0;
    check("wr_resp_o_single", 256'(resp_o), 256'(1'b0));
  endtask

  initial begin
    // Reset, then idle with resp_i noise: everything stays zero.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      resp_i = i[0];
      check("idle_outputs",
            256'({line_o, burst_o, address_o, read_o, write_o, resp_o}), 256'(0));
      step();
    end
    resp_i = 1'b0;
    check("idle_resp_cnt", 256'(resp_cnt), 256'(0));

    // Back-to-back beats: resp_o lands 5 cycles after the request.
    read_line(32'h1234_567F, 32'h1234_5660, L_RD1, 0, 0, 0, 0);

    // Gapped beats give the same line.
    read_line(32'h1234_567F, 32'h1234_5660, L_RD1, 0, 2, 1, 3);

    // Writeback leaves line_o alone.
    write_line(32'h8000_0020, 32'h8000_0020, L_WR, L_RD1);

    // Write, then read issued the cycle after resp_o.
    write_line(32'h8000_003C, 32'h8000_0020, L_WR, L_RD1);
    read_line(32'h0000_1044, 32'h0000_1040, L_RD2, 0, 0, 0, 0);
    check("b2b_resp_cnt", 256'(resp_cnt), 256'(5));

    // Reset after two read beats: outputs clear at once, no resp_o.
    read_i    = 1'b1;
    address_i = 32'h0000_2000;
    step();
    for (int k = 0; k < 2; k++) begin
      resp_i  = 1'b1;
      burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      step();
    end
    resp_i  = 1'b0;
    read_i  = 1'b0;
    check("pre_rst_read_o", 256'(read_o), 256'(1'b1));
    rst = 1'b1;
    #1;
    check("async_rst_outputs",
          256'({burst_o, address_o, read_o, write_o, resp_o}), 256'(0));
    check("async_rst_line_o", line_o, 256'(0));
    step();
    rst = 1'b0;
    step();
    check("post_rst_resp_cnt", 256'(resp_cnt), 256'(5));
    read_line(32'hFFFF_FFFF, 32'hFFFF_FFE0, L_RD3, 1, 0, 0, 0);
    check("final_resp_cnt", 256'(resp_cnt), 256'(6));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Sits directly downstream of the L2 cache's physical-memory port. It converts single-cycle 256-bit line reads and writebacks into 4-beat 64-bit bursts on the physical memory bus. On reads it assembles the beats into a line; on writes it serialises the line. It returns a single pmem_resp-style pulse to the L2 when the burst is finished.

Parameters:
BURST_W, 64, width of one memory beat in bits
BEATS, 4, beats per line; line width = BURST_W*BEATS = 256
OFFSET_W, 5, byte-offset bits of a line; cleared on the outgoing address

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
line_i  input  256  writeback line from L2 (pmem_wdata)
line_o  output  256  assembled read line to L2 (pmem_rdata)
address_i  input  32  line address from L2 (pmem_address)
read_i  input  1  L2 line read request (pmem_read), held until resp_o
write_i  input  1  L2 line write request (pmem_write), held until resp_o
resp_o  output  1  one-cycle completion pulse to L2 (pmem_resp)
burst_i  input  64  read beat from memory
burst_o  output  64  write beat to memory
address_o  output  32  aligned burst address to memory
read_o  output  1  burst read request to memory
write_o  output  1  burst write request to memory
resp_i  input  1  memory beat-accept / beat-valid strobe

Behaviour:
- Reset (asynchronous, any time):
  - State goes to IDLE; beat counter = 0; line buffer = 0.
  - Outputs: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - A reset mid-burst abandons the burst. No resp_o is issued.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE, request sampling:
  - If write_i=1, latch line_i and address_i, then go to WR_BURST. Write has priority if both requests are high; both high is illegal from L2.
  - Else if read_i=1, latch address_i and go to RD_BURST.
  - Latched address = {address_i[31:OFFSET_W], OFFSET_W zeros}. The address is not re-sampled during the burst.
- RD_BURST:
  - read_o=1 and address_o = latched address, registered, so they are first visible the cycle after the request is sampled.
  - Each cycle resp_i=1 stores burst_i into buffer slice [64*k+63:64*k] for the current k, then k increments. Beat 0 is the low bits.
  - resp_i gaps are allowed and the counter holds across them.
  - After the 4th accepted beat: read_o drops the next cycle and the FSM goes to DONE.
- WR_BURST:
  - write_o=1, address_o = latched address, burst_o = latched line slice k.
  - Each resp_i=1 advances k, and burst_o presents the next slice the following cycle.
  - After the 4th accepted beat: write_o drops and the FSM goes to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then back to IDLE.
  - On reads, line_o = assembled line, valid from the DONE cycle.
  - line_o holds until the next read's DONE; writes do not disturb it.
- Handshake rule for L2: L2 deasserts its request in the cycle after resp_o, and IDLE never re-accepts a request in the same cycle resp_o is high.
  - Minimum turnaround: request sampled at cycle 0, read_o/write_o high from cycle 1.
  - With back-to-back resp_i at cycles 1-4, resp_o is high at cycle 5.
- Counter is 2 bits and wraps 3->0 on the final beat, so it is 0 in DONE/IDLE.
- resp_i in IDLE or DONE is ignored and changes no state.
- read_o and write_o are never high together. resp_o never coincides with read_o or write_o.

Test Plan:
- Reset then idle: rst pulse, no requests -> all outputs 0 for 10 cycles; resp_i=1 noise in IDLE causes no resp_o.
- Consecutive read: address_i=0x1234_567F, read_i; memory returns beats 0x0..0x3 (beat k = 64'h1111_1111_1111_1111*(k+1)) on 4 back-to-back resp_i.
  -> address_o=0x1234_5660.
  -> resp_o pulses exactly one cycle, 5 cycles after the request.
  -> line_o = {4444..,3333..,2222..,1111..}.
- Gapped read: same as above with resp_i gaps of 0, 2, 1, 3 idle cycles between beats -> identical line_o; resp_o one cycle after the 4th beat; read_o high throughout the burst.
- Writeback: line_i = 256'h{D,C,B,A} 64-bit words, write_i, address 0x8000_0020 -> burst_o = A, B, C, D on successive accepted beats; write_o falls after beat D; single resp_o; line_o unchanged from the prior read.
- Back-to-back: write then read issued the cycle after resp_o -> second request is accepted, with no lost or duplicated resp_o; the write FSM did not corrupt read data.
- Reset mid-burst: assert rst after 2 read beats -> outputs 0 immediately (asynchronous); a new read afterwards completes correctly, with beats stored from slot 0.
